sd_spi_responder: RTL

SD_SPI_RESPONDER -- requirements
Module: sd_spi_responder

---
 rtl/sd_pkg.sv | 46 ++++
 rtl/sd_crc7.sv | 27 ++
 rtl/sd_spi_responder.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/sd_pkg.sv
// ============================================================================
// sd_pkg : shared command indices, tokens, R1 bit positions and FSM states
// Revision: 1.0
// ============================================================================
`default_nettype none

package sd_pkg;

  localparam logic [5:0] CMD_GO_IDLE      = 6'd0;
  localparam logic [5:0] CMD_SEND_IF_COND = 6'd8;
  localparam logic [5:0] CMD_READ_SINGLE  = 6'd17;
  localparam logic [5:0] ACMD_SEND_OP     = 6'd41;
  localparam logic [5:0] CMD_APP_CMD      = 6'd55;

  localparam logic [7:0] TOKEN_START      = 8'hFE;
  localparam logic [7:0] TOKEN_ERR_RANGE  = 8'h08;

  localparam int R1_IDLE    = 0;
  localparam int R1_ILLEGAL = 2;
  localparam int R1_CRC_ERR = 3;
  localparam int R1_PARAM   = 6;

  typedef enum logic [2:0] {
    RxCmd     = 3'd0,
    Ncr       = 3'd1,
    SendResp  = 3'd2,
    WaitData  = 3'd3,
    SendToken = 3'd4,
    SendData  = 3'd5,
    SendCrc   = 3'd6
  } sd_state_e;

  function automatic logic [7:0] r1_build(input logic idle, input logic illegal,
                                          input logic crc_err, input logic param_err);
    logic [7:0] r;
    r             = 8'h00;
    r[R1_IDLE]    = idle;
    r[R1_ILLEGAL] = illegal;
    r[R1_CRC_ERR] = crc_err;
    r[R1_PARAM]   = param_err;
    return r;
  endfunction

endpackage

`default_nettype wire

// File: rtl/sd_crc7.sv
// ============================================================================
// sd_crc7 : CRC7 (x^7+x^3+1) over a 40-bit command head, bit-serial LFSR form
// Exists only when SD_RESPONDER_CRC_CHECK_EN is defined.  Revision: 1.0
// ============================================================================
`default_nettype none

`ifdef SD_RESPONDER_CRC_CHECK_EN
module sd_crc7 (
  input  logic [39:0] data,
  output logic [6:0]  crc
);

  logic fb;

  always_comb begin
    crc = 7'h00;
    fb  = 1'b0;
    for (int i = 39; i >= 0; i--) begin
      fb  = data[i] ^ crc[6];
      crc = {crc[5:0], 1'b0} ^ (fb ? 7'h09 : 7'h00);
    end
  end

endmodule
`endif

`default_nettype wire

// File: rtl/sd_spi_responder.sv
// ============================================================================
// sd_spi_responder : SPI-mode SD card responder (init sequence + CMD17 reads)
// Option: SD_RESPONDER_CRC_CHECK_EN enables command CRC7 checking.  Revision: 1.0
// ============================================================================
`default_nettype none

module sd_spi_responder
  import sd_pkg::*;
#(
  parameter int NUM_BLOCKS        = 1024,
  parameter int ACMD41_BUSY_POLLS = 2,
  parameter int MEM_ADDR_W        = 19
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  cs,
  input  logic                  mosi,
  output logic                  miso,
  output logic                  mem_rd_en,
  output logic [MEM_ADDR_W-1:0] mem_addr,
  input  logic [7:0]            mem_rd_data,
  output logic                  initialized
);

  localparam int              BLK_W      = MEM_ADDR_W - 9;
  localparam int              POLL_W     = $clog2(ACMD41_BUSY_POLLS + 2);
  localparam logic [31:0]     BLOCKS_W   = 32'(NUM_BLOCKS);
  localparam logic [POLL_W-1:0] BUSY_POLLS = POLL_W'(ACMD41_BUSY_POLLS);

  sd_state_e         state, state_next;
  logic [47:0]       shifter, sh_next;
  logic              frame, crc_bad, take_cmd;
  logic [5:0]        cmd_idx;
  logic [31:0]       cmd_arg;
  logic [5:0]        cnt;
  logic [8:0]        byte_cnt, rd_idx;
  logic [39:0]       resp_sr;
  logic              resp_long, rd_ok, rd_err, app_flag;
  logic [POLL_W-1:0] polls;
  logic [BLK_W-1:0]  blk;
  logic [7:0]        data_sr, token;
  logic              rd_next, load_data;

  logic [39:0]       dec_resp;
  logic              dec_long, dec_ok, dec_err, dec_app, dec_init;
  logic [POLL_W-1:0] dec_polls;

  assign sh_next  = {shifter[46:0], mosi};
  assign frame    = (sh_next[47:46] == 2'b01) && sh_next[0];
  assign cmd_idx  = sh_next[45:40];
  assign cmd_arg  = sh_next[39:8];
  assign take_cmd = (state == RxCmd) && !cs && frame;

`ifdef SD_RESPONDER_CRC_CHECK_EN
  logic [6:0] crc_calc;
  sd_crc7 u_crc7 (.data(sh_next[47:8]), .crc(crc_calc));
  assign crc_bad = (crc_calc != sh_next[7:1]);
`else
  assign crc_bad = 1'b0;
`endif

  // Response and flag updates for the frame completing this cycle.
  always_comb begin
    dec_resp  = {r1_build(~initialized, 1'b1, 1'b0, 1'b0), 32'hFFFF_FFFF};
    dec_long  = 1'b0;
    dec_ok    = 1'b0;
    dec_err   = 1'b0;
    dec_app   = 1'b0;
    dec_init  = initialized;
    dec_polls = polls;
    if (crc_bad) begin
      dec_resp[39:32] = r1_build(~initialized, 1'b0, 1'b1, 1'b0);
      dec_app         = app_flag;
    end else begin
      case (cmd_idx)
        CMD_GO_IDLE: begin
          dec_resp[39:32] = r1_build(1'b1, 1'b0, 1'b0, 1'b0);
          dec_init        = 1'b0;
          dec_polls       = '0;
        end
        CMD_SEND_IF_COND: begin
          dec_resp = {r1_build(~initialized, 1'b0, 1'b0, 1'b0), 8'h00, 8'h00,
                      4'h0, cmd_arg[11:8], cmd_arg[7:0]};
          dec_long = 1'b1;
        end
        CMD_APP_CMD: begin
          dec_resp[39:32] = r1_build(~initialized, 1'b0, 1'b0, 1'b0);
          dec_app         = 1'b1;
        end
        ACMD_SEND_OP: begin
          if (app_flag) begin
            if (polls < BUSY_POLLS) begin
              dec_resp[39:32] = r1_build(1'b1, 1'b0, 1'b0, 1'b0);
              dec_polls       = polls + POLL_W'(1);
            end else begin
              dec_resp[39:32] = 8'h00;
              dec_init        = 1'b1;
            end
          end
        end
        CMD_READ_SINGLE: begin
          if (cmd_arg >= BLOCKS_W) begin
            dec_resp[39:32] = r1_build(1'b0, 1'b0, 1'b0, 1'b1);
            dec_err         = 1'b1;
          end else if (initialized) begin
            dec_resp[39:32] = 8'h00;
            dec_ok          = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= RxCmd;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      RxCmd:     if (take_cmd) state_next = Ncr;
      Ncr:       if (cnt == 6'd7) state_next = SendResp;
      SendResp:  if (cnt == (resp_long ? 6'd39 : 6'd7))
                   state_next = (rd_ok || rd_err) ? WaitData : RxCmd;
      WaitData:  if (cnt == 6'd7) state_next = SendToken;
      SendToken: if (cnt == 6'd7) state_next = rd_ok ? SendData : RxCmd;
      SendData:  if (cnt[2:0] == 3'd7 && byte_cnt == 9'd511) state_next = SendCrc;
      SendCrc:   if (cnt == 6'd15) state_next = RxCmd;
      default:   state_next = RxCmd;
    endcase
    if (cs) state_next = RxCmd;
  end

  // Each byte's read is issued on bit 5 so the registered memory data lands before bit 0.
  always_comb begin
    token     = rd_ok ? TOKEN_START : TOKEN_ERR_RANGE;
    miso      = 1'b1;
    case (state)
      SendResp:  miso = resp_sr[39];
      SendToken: miso = token[3'd7 - cnt[2:0]];
      SendData:  miso = data_sr[3'd7 - cnt[2:0]];
      default:   miso = 1'b1;
    endcase
    if (cs) miso = 1'b1;
    rd_next   = !cs && (((state == SendToken) && rd_ok && (cnt == 6'd5)) ||
                        ((state == SendData) && (cnt[2:0] == 3'd5) && (byte_cnt != 9'd511)));
    load_data = ((state == SendToken) && (cnt == 6'd7)) ||
                ((state == SendData) && (cnt[2:0] == 3'd7));
    rd_idx    = (state == SendToken) ? 9'd0 : byte_cnt + 9'd1;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      shifter     <= '0;
      cnt         <= '0;
      byte_cnt    <= '0;
      resp_sr     <= '1;
      resp_long   <= 1'b0;
      rd_ok       <= 1'b0;
      rd_err      <= 1'b0;
      app_flag    <= 1'b0;
      initialized <= 1'b0;
      polls       <= '0;
      blk         <= '0;
      data_sr     <= '0;
      mem_rd_en   <= 1'b0;
      mem_addr    <= '0;
    end else begin
      if (cs || take_cmd) begin
        shifter <= '0;
      end else if (state == RxCmd) begin
        shifter <= sh_next;
      end
      if (take_cmd) begin
        resp_sr     <= dec_resp;
        resp_long   <= dec_long;
        rd_ok       <= dec_ok;
        rd_err      <= dec_err;
        app_flag    <= dec_app;
        initialized <= dec_init;
        polls       <= dec_polls;
        blk         <= cmd_arg[BLK_W-1:0];
        byte_cnt    <= '0;
      end else if (state == SendResp) begin
        resp_sr <= {resp_sr[38:0], 1'b1};
      end
      if ((state_next != state) || ((state == SendData) && (cnt[2:0] == 3'd7))) begin
        cnt <= '0;
      end else begin
        cnt <= cnt + 6'd1;
      end
      if ((state == SendData) && (cnt[2:0] == 3'd7)) begin
        byte_cnt <= byte_cnt + 9'd1;
      end
      if (load_data) begin
        data_sr <= mem_rd_data;
      end
      mem_rd_en <= rd_next;
      if (rd_next) begin
        mem_addr <= {blk, rd_idx};
      end
    end
  end

endmodule

`default_nettype wire
